// File: rtl/down_counter_3_bit.sv
// Cascadable 3-bit down counter with parallel load, programmable reload on
// underflow, a combinational borrow-out and a registered underflow pulse.
module down_counter_3_bit (
    input  logic       clk,
    input  logic       reset,
    input  logic       count,
    input  logic       load,
    input  logic [2:0] din,
    input  logic       reload_en,
    output logic [2:0] out,
    output logic       next,
    output logic       tick
);

    localparam int unsigned W = 3;

    logic [W-1:0] rld;
    logic         at_zero;
    logic [W-1:0] underflow_val;

    assign at_zero = (out == W'(0));

    // Borrow-out is suppressed by load and by reset so a cascade never sees a stale borrow.
    assign next = count & ~load & ~reset & at_zero;

    // reload_en is consulted only here, i.e. at the underflow edge.
    assign underflow_val = reload_en ? rld : {W{1'b1}};

    always_ff @(posedge clk) begin
        if (reset) begin
            out  <= W'(0);
            rld  <= W'(0);
            tick <= 1'b0;
        end else begin
            tick <= next;
            if (load) begin
                out <= din;
                rld <= din;
            end else if (count) begin
                if (at_zero) begin
                    out <= underflow_val;
                end else begin
                    out <= out - W'(1);
                end
            end
        end
    end

endmodule

// File: tb/tb_down_counter_3_bit.sv
// Self-checking bench for down_counter_3_bit: reference model feeds a queue of
// expected post-edge values, plus a two-stage cascade checked as a 6-bit counter.
module tb_down_counter_3_bit;

    typedef struct packed {
        logic [2:0] out;
        logic       tick;
    } exp_t;

    logic       clk;
    logic       reset, count, load, reload_en;
    logic [2:0] din;
    logic [2:0] out;
    logic       next, tick;

    logic       c_reset, c_count;
    logic [2:0] lo_out, hi_out;
    logic       lo_next, hi_next, lo_tick, hi_tick;

    int checks;
    int failures;

    exp_t       sb_q[$];
    logic [2:0] m_out, m_rld;
    logic       m_tick;

    down_counter_3_bit dut (
        .clk(clk), .reset(reset), .count(count), .load(load), .din(din),
        .reload_en(reload_en), .out(out), .next(next), .tick(tick)
    );

    down_counter_3_bit u_lo (
        .clk(clk), .reset(c_reset), .count(c_count), .load(1'b0), .din(3'b000),
        .reload_en(1'b0), .out(lo_out), .next(lo_next), .tick(lo_tick)
    );

    down_counter_3_bit u_hi (
        .clk(clk), .reset(c_reset), .count(lo_next), .load(1'b0), .din(3'b000),
        .reload_en(1'b0), .out(hi_out), .next(hi_next), .tick(hi_tick)
    );

    initial clk = 1'b0;
    always #5 clk = ~clk;

    // One clock of stimulus: sample next before the edge, update model, push expectation.
    task automatic drive(input logic r, input logic c, input logic l, input logic [2:0] d,
                         input logic re, output logic obs_next, output logic exp_next);
        exp_t e;
        reset = r; count = c; load = l; din = d; reload_en = re;
        #1;
        obs_next = next;
        exp_next = c & ~l & ~r & (m_out == 3'd0);
        if (r) begin
            m_out = 3'd0; m_rld = 3'd0; m_tick = 1'b0;
        end else begin
            m_tick = exp_next;
            if (l) begin
                m_out = d; m_rld = d;
            end else if (c) begin
                if (m_out == 3'd0) m_out = re ? m_rld : 3'd7;
                else               m_out = m_out - 3'd1;
            end
        end
        e.out = m_out; e.tick = m_tick;
        sb_q.push_back(e);
        @(posedge clk);
        #1;
    endtask

    task automatic test_reset();
        logic on, en;
        exp_t e;
        drive(1'b1, 1'b1, 1'b1, 3'd6, 1'b1, on, en);
        e = sb_q.pop_front();
        checks++;
        if (on !== 1'b0) begin failures++; $display("FAIL reset_next got=%b want=0", on); end
        checks++;
        if (out !== 3'd0 || out !== e.out) begin failures++; $display("FAIL reset_out got=%0d want=0", out); end
        checks++;
        if (tick !== 1'b0) begin failures++; $display("FAIL reset_tick got=%b want=0", tick); end
    endtask

    task automatic test_wrap();
        logic on, en;
        exp_t e;
        logic [2:0] seq [9];
        logic       nx  [9];
        seq = '{3'd7, 3'd6, 3'd5, 3'd4, 3'd3, 3'd2, 3'd1, 3'd0, 3'd7};
        nx  = '{1'b1, 1'b0, 1'b0, 1'b0, 1'b0, 1'b0, 1'b0, 1'b0, 1'b1};
        drive(1'b1, 1'b0, 1'b0, 3'd0, 1'b0, on, en);
        void'(sb_q.pop_front());
        for (int i = 0; i < 9; i++) begin
            drive(1'b0, 1'b1, 1'b0, 3'd0, 1'b0, on, en);
            e = sb_q.pop_front();
            checks++;
            if (on !== nx[i] || on !== en) begin
                failures++; $display("FAIL wrap_next[%0d] got=%b want=%b", i, on, nx[i]);
            end
            checks++;
            if (out !== seq[i] || out !== e.out) begin
                failures++; $display("FAIL wrap_out[%0d] got=%0d want=%0d", i, out, seq[i]);
            end
            checks++;
            if (tick !== nx[i] || tick !== e.tick) begin
                failures++; $display("FAIL wrap_tick[%0d] got=%b want=%b", i, tick, nx[i]);
            end
        end
    endtask

    task automatic test_reload();
        logic on, en;
        exp_t e;
        logic [2:0] seq [9];
        seq = '{3'd1, 3'd0, 3'd2, 3'd1, 3'd0, 3'd2, 3'd1, 3'd0, 3'd2};
        drive(1'b0, 1'b0, 1'b1, 3'd2, 1'b1, on, en);
        e = sb_q.pop_front();
        checks++;
        if (out !== 3'd2 || out !== e.out) begin failures++; $display("FAIL reload_load got=%0d want=2", out); end
        for (int i = 0; i < 9; i++) begin
            drive(1'b0, 1'b1, 1'b0, 3'd0, 1'b1, on, en);
            e = sb_q.pop_front();
            checks++;
            if (out !== seq[i] || out !== e.out || tick !== e.tick || on !== en) begin
                failures++;
                $display("FAIL reload[%0d] out=%0d tick=%b next=%b want out=%0d tick=%b next=%b",
                         i, out, tick, on, seq[i], e.tick, en);
            end
        end
    endtask

    task automatic test_div1();
        logic on, en;
        exp_t e;
        drive(1'b0, 1'b0, 1'b1, 3'd0, 1'b1, on, en);
        void'(sb_q.pop_front());
        for (int i = 0; i < 5; i++) begin
            drive(1'b0, 1'b1, 1'b0, 3'd0, 1'b1, on, en);
            e = sb_q.pop_front();
            checks++;
            if (on !== 1'b1 || out !== 3'd0 || tick !== 1'b1 || e.tick !== 1'b1) begin
                failures++;
                $display("FAIL div1[%0d] next=%b out=%0d tick=%b want next=1 out=0 tick=1", i, on, out, tick);
            end
        end
    endtask

    task automatic test_load_priority();
        logic on, en;
        exp_t e;
        drive(1'b0, 1'b0, 1'b1, 3'd0, 1'b0, on, en);
        void'(sb_q.pop_front());
        drive(1'b0, 1'b1, 1'b1, 3'd5, 1'b0, on, en);
        e = sb_q.pop_front();
        checks++;
        if (on !== 1'b0 || en !== 1'b0) begin failures++; $display("FAIL loadprio_next got=%b want=0", on); end
        checks++;
        if (out !== 3'd5 || out !== e.out) begin failures++; $display("FAIL loadprio_out got=%0d want=5", out); end
        checks++;
        if (tick !== 1'b0) begin failures++; $display("FAIL loadprio_tick got=%b want=0", tick); end
    endtask

    task automatic test_reload_en_sample();
        logic on, en;
        exp_t e;
        logic [2:0] seq [6];
        logic       re  [6];
        seq = '{3'd2, 3'd1, 3'd0, 3'd3, 3'd2, 3'd1};
        re  = '{1'b0, 1'b1, 1'b0, 1'b1, 1'b0, 1'b0};
        drive(1'b0, 1'b0, 1'b1, 3'd3, 1'b0, on, en);
        void'(sb_q.pop_front());
        for (int i = 0; i < 6; i++) begin
            drive(1'b0, 1'b1, 1'b0, 3'd0, re[i], on, en);
            e = sb_q.pop_front();
            checks++;
            if (out !== seq[i] || out !== e.out || tick !== e.tick) begin
                failures++;
                $display("FAIL reen[%0d] out=%0d tick=%b want out=%0d tick=%b", i, out, tick, seq[i], e.tick);
            end
        end
    endtask

    task automatic test_hold();
        logic on, en;
        exp_t e;
        for (int i = 0; i < 3; i++) begin
            drive(1'b0, 1'b0, 1'b0, 3'd6, 1'b1, on, en);
            e = sb_q.pop_front();
            checks++;
            if (out !== 3'd1 || out !== e.out || on !== 1'b0 || tick !== 1'b0) begin
                failures++; $display("FAIL hold[%0d] out=%0d next=%b tick=%b want out=1 next=0 tick=0", i, out, on, tick);
            end
        end
    endtask

    task automatic test_reset_mid();
        logic on, en;
        exp_t e;
        drive(1'b0, 1'b0, 1'b1, 3'd0, 1'b1, on, en);
        void'(sb_q.pop_front());
        drive(1'b0, 1'b1, 1'b0, 3'd0, 1'b1, on, en);
        void'(sb_q.pop_front());
        drive(1'b0, 1'b0, 1'b1, 3'd4, 1'b1, on, en);
        void'(sb_q.pop_front());
        drive(1'b0, 1'b1, 1'b0, 3'd0, 1'b1, on, en);
        void'(sb_q.pop_front());
        drive(1'b0, 1'b1, 1'b0, 3'd0, 1'b1, on, en);
        void'(sb_q.pop_front());
        drive(1'b0, 1'b1, 1'b0, 3'd0, 1'b1, on, en);
        void'(sb_q.pop_front());
        checks++;
        if (out !== 3'd1) begin failures++; $display("FAIL rstmid_pre got=%0d want=1", out); end
        drive(1'b0, 1'b1, 1'b0, 3'd0, 1'b1, on, en);
        void'(sb_q.pop_front());
        drive(1'b1, 1'b1, 1'b0, 3'd0, 1'b1, on, en);
        e = sb_q.pop_front();
        checks++;
        if (on !== 1'b0) begin failures++; $display("FAIL rstmid_next got=%b want=0", on); end
        checks++;
        if (out !== 3'd0 || tick !== 1'b0 || e.tick !== 1'b0) begin
            failures++; $display("FAIL rstmid_state out=%0d tick=%b want out=0 tick=0", out, tick);
        end
        drive(1'b0, 1'b1, 1'b0, 3'd0, 1'b1, on, en);
        e = sb_q.pop_front();
        checks++;
        if (on !== 1'b1 || out !== 3'd0 || out !== e.out) begin
            failures++; $display("FAIL rstmid_rld out=%0d next=%b want out=0 next=1", out, on);
        end
    endtask

    task automatic test_random();
        logic on, en, r, c, l, re;
        logic [2:0] d;
        exp_t e;
        for (int i = 0; i < 300; i++) begin
            r  = ($urandom_range(0, 19) == 0);
            l  = ($urandom_range(0, 7) == 0);
            c  = ($urandom_range(0, 3) != 0);
            re = 1'($urandom_range(0, 1));
            d  = 3'($urandom_range(0, 7));
            drive(r, c, l, d, re, on, en);
            e = sb_q.pop_front();
            checks++;
            if (on !== en || out !== e.out || tick !== e.tick) begin
                failures++;
                $display("FAIL random[%0d] out=%0d tick=%b next=%b want out=%0d tick=%b next=%b",
                         i, out, tick, on, e.out, e.tick, en);
            end
        end
    endtask

    task automatic test_cascade();
        logic [5:0] val;
        logic [2:0] prev_hi, prev_lo;
        c_reset = 1'b1; c_count = 1'b1;
        @(posedge clk); #1;
        c_reset = 1'b0;
        val = 6'd0;
        checks++;
        if ({hi_out, lo_out} !== val) begin failures++; $display("FAIL cascade_reset got=%0d want=0", {hi_out, lo_out}); end
        for (int i = 0; i < 70; i++) begin
            prev_hi = hi_out; prev_lo = lo_out;
            @(posedge clk); #1;
            val = val - 6'd1;
            checks++;
            if ({hi_out, lo_out} !== val || (hi_out !== prev_hi && prev_lo !== 3'd0)) begin
                failures++; $display("FAIL cascade[%0d] got=%0d want=%0d", i, {hi_out, lo_out}, val);
            end
        end
        c_count = 1'b0;
    endtask

    initial begin
        checks = 0; failures = 0;
        m_out = 3'd0; m_rld = 3'd0; m_tick = 1'b0;
        reset = 1'b1; count = 1'b0; load = 1'b0; din = 3'd0; reload_en = 1'b0;
        c_reset = 1'b1; c_count = 1'b0;
        @(posedge clk); #1;
        test_reset();
        test_wrap();
        test_reload();
        test_div1();
        test_load_priority();
        test_reload_en_sample();
        test_hold();
        test_reset_mid();
        test_random();
        test_cascade();
        $display("TB_RESULT checks=%0d failures=%0d", checks, failures);
        $finish;
    end

endmodule

// File: doc/down_counter_3_bit.md
DOWN_COUNTER_3_BIT -- requirements
Module: down_counter_3_bit

Interface
REQ-001 SHALL have port: clk  input  1  single clock; all state updates on rising edge.
REQ-002 SHALL have port: reset  input  1  synchronous, active-high reset, sampled on the rising edge of clk.
REQ-003 SHALL have port: count  input  1  decrement enable / borrow-in from the lower stage.
REQ-004 SHALL have port: load  input  1  parallel-load strobe.
REQ-005 SHALL have port: din  input  3  parallel-load value.
REQ-006 SHALL have port: reload_en  input  1  1 = on underflow reload from reload register; 0 = wrap to 3'b111.
REQ-007 SHALL have port: out  output  3  current count value, registered.
REQ-008 SHALL have port: next  output  1  borrow-out to the next stage, combinational.
REQ-009 SHALL have port: tick  output  1  registered one-cycle underflow pulse.

Function
REQ-010 SHALL hold an internal 3-bit reload register (rld) in addition to out.
REQ-011 SHALL apply update priority per clk edge: reset > load > count > hold.
REQ-012 On load=1, SHALL set out<=din and rld<=din, ignoring count.
REQ-013 On load=0, count=1, out!=3'b000, SHALL set out<=out-1 (modulo-8 unsigned).
REQ-014 On load=0, count=1, out==3'b000, reload_en=1, SHALL set out<=rld.
REQ-015 On load=0, count=1, out==3'b000, reload_en=0, SHALL set out<=3'b111.
REQ-016 On load=0, count=0, SHALL hold out and rld.
REQ-017 SHALL drive next = count & ~load & (out==3'b000) combinationally in the same cycle, so stages cascade by wiring next to the following stage's count.
REQ-018 SHALL register tick<=next each edge, giving a one-cycle pulse in the cycle after underflow.
REQ-019 With reload_en=1 and count held high, SHALL underflow once every rld+1 cycles (divide-by-(rld+1)); rld=3'b000 SHALL give next=1 every count cycle with out remaining 3'b000.
REQ-020 SHALL sample reload_en at the underflow edge only; changing it mid-count SHALL NOT alter out until the next underflow.
REQ-021 load and count asserted together SHALL load din, deassert next, and produce no tick on the following cycle.
REQ-022 rld SHALL change only on load or reset, never on underflow.

Reset
REQ-023 On reset=1 at a clk edge, SHALL set out=3'b000, rld=3'b000, tick=0, overriding load and count.
REQ-024 While reset=1, next SHALL be 0; the first count after reset release with out=3'b000 SHALL assert next.
REQ-025 Reset asserted mid-count SHALL take effect at that edge with no residual tick in the following cycle.

Verification
REQ-026 Reset, then count=1 for 9 cycles, reload_en=0 -> out sequence 0,7,6,5,4,3,2,1,0; next=1 in cycles 1 and 9; tick one cycle later each time.
REQ-027 load=1 din=3'b010, then reload_en=1, count=1 continuous -> out 2,1,0,2,1,0...; tick period 3 cycles.
REQ-028 load=1 din=3'b000, reload_en=1, count=1 -> out stays 0; next=1 every cycle; tick=1 from the second cycle on.
REQ-029 out=3'b000, count=1 and load=1 din=3'b101 in the same cycle -> next=0, out=5 next cycle, tick=0.
REQ-030 Two instances cascaded (low.next -> high.count), both reset, count=1 -> combined 6-bit value decrements 0,63,62,...; high stage changes only when low out=0.
REQ-031 reset=1 asserted while out=3'b000 and count=1 -> next=0 that cycle, out=0 and tick=0 the next cycle; rld=0 afterwards.
